// File: rtl/memory_stage_pkg.sv
// Shared memory-stage encodings: mem_op codes, FSM states and op-class helpers.
// No logic; imported by the memory stage and by decode/execute.
// Backpressure is not applicable (package only).
package memory_stage_pkg;

  typedef enum logic [2:0] {
    MEM_NOP    = 3'd0,
    MEM_LOAD   = 3'd1,
    MEM_STORE  = 3'd2,
    MEM_PUSH   = 3'd3,
    MEM_POP    = 3'd4,
    MEM_PUSH32 = 3'd5,
    MEM_POP32  = 3'd6,
    MEM_NOP7   = 3'd7
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_SP_RESET = 2047;

  // Ops that take two cycles and raise busy in their first cycle.
  function automatic logic is_wide_op(mem_op_e op);
    return (op == MEM_PUSH32) || (op == MEM_POP32);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-memory-stage bundle plus the registered results toward writeback.
// Pure wiring, no latency.
// Upstream must hold its inputs while busy is high.
interface memory_stage_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic                  in_valid;
  logic [2:0]            mem_op;
  logic [15:0]           alu_result;
  logic [DATA_W-1:0]     store_data;
  logic [2*DATA_W-1:0]   push32_data;
  logic [2:0]            rd_in;
  logic                  wb_en_in;
  logic                  busy;
  logic                  out_valid;
  logic [DATA_W-1:0]     result;
  logic [2*DATA_W-1:0]   result32;
  logic [2:0]            rd_out;
  logic                  wb_en_out;
  logic [ADDR_W-1:0]     sp_out;
  logic                  stack_fault;

  // Execute side.
  modport master (
    output in_valid, mem_op, alu_result, store_data, push32_data, rd_in, wb_en_in,
    input  busy, out_valid, result, result32, rd_out, wb_en_out, sp_out, stack_fault
  );

  // Memory stage side.
  modport slave (
    input  in_valid, mem_op, alu_result, store_data, push32_data, rd_in, wb_en_in,
    output busy, out_valid, result, result32, rd_out, wb_en_out, sp_out, stack_fault
  );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Single-port data memory: synchronous write, combinational read, no reset.
// Read data valid in the same cycle as the address; write lands on the clock edge.
// No backpressure; one access per cycle by construction.
module data_memory #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// Memory stage: LOAD/STORE, PUSH/POP and 2-cycle PUSH32/POP32; owns the stack pointer.
// Single-word ops: 1 cycle to out_valid; 32-bit ops: 2 cycles. Optional macro: STACK_GUARD_EN.
// busy is raised combinationally in the first cycle of a 32-bit op; inputs are ignored in SECOND.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SP_RESET = DEF_SP_RESET
) (
  input  logic clk,
  input  logic rst,
  memory_stage_if.slave bus
);
  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  state_e              state;
  mem_op_e             op;
  logic [ADDR_W-1:0]   sp, sp_inc, sp_dec;
  logic [DATA_W-1:0]   word_hold;     // PUSH32 low word to write, or POP32 low word read
  logic                second_pop;    // SECOND cycle belongs to POP32 (else PUSH32)
  logic [2:0]          rd_hold;
  logic                wb_hold;
  logic                mem_we, fault;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;
  logic                out_valid_q, wb_en_q, fault_q;
  logic [DATA_W-1:0]   result_q;
  logic [2*DATA_W-1:0] result32_q;
  logic [2:0]          rd_q;

  assign op     = mem_op_e'(bus.mem_op);
  assign sp_inc = sp + 1'b1;
  assign sp_dec = sp - 1'b1;

  // Single address port: pick the access address, write enable and guard fault for this cycle.
  always_comb begin
    mem_addr  = bus.alu_result[ADDR_W-1:0];
    mem_wdata = bus.store_data;
    mem_we    = 1'b0;
    fault     = 1'b0;
    if (state == ST_SECOND) begin
      if (second_pop) begin
        mem_addr = sp_inc;
        fault    = GUARD && (sp == SP_INIT);
      end else begin
        mem_addr  = sp;
        mem_wdata = word_hold;
        fault     = GUARD && (sp == '0);
        mem_we    = !fault;
      end
    end else if (bus.in_valid) begin
      case (op)
        MEM_STORE: mem_we = 1'b1;
        MEM_PUSH, MEM_PUSH32: begin
          mem_addr  = sp;
          mem_wdata = (op == MEM_PUSH32) ? bus.push32_data[2*DATA_W-1:DATA_W] : bus.store_data;
          fault     = GUARD && (sp == '0);
          mem_we    = !fault;
        end
        MEM_POP, MEM_POP32: begin
          mem_addr = sp_inc;
          fault    = GUARD && (sp == SP_INIT);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == ST_IDLE) && bus.in_valid && is_wide_op(op) && !fault;

  data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // FSM, stack pointer and writeback-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sp          <= SP_INIT;
      word_hold   <= '0;
      second_pop  <= 1'b0;
      rd_hold     <= '0;
      wb_hold     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result32_q  <= '0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      if (state == ST_SECOND) begin
        state       <= ST_IDLE;
        out_valid_q <= 1'b1;
        rd_q        <= rd_hold;
        if (fault) begin
          fault_q <= 1'b1;
          wb_en_q <= 1'b0;
        end else if (second_pop) begin
          sp         <= sp_inc;
          result32_q <= {mem_rdata, word_hold};
          wb_en_q    <= wb_hold;
        end else begin
          sp      <= sp_dec;
          wb_en_q <= 1'b0;
        end
      end else if (bus.in_valid) begin
        if (fault) begin
          out_valid_q <= 1'b1;
          fault_q     <= 1'b1;
          rd_q        <= bus.rd_in;
          wb_en_q     <= 1'b0;
        end else begin
          case (op)
            MEM_PUSH32, MEM_POP32: begin
              state      <= ST_SECOND;
              second_pop <= (op == MEM_POP32);
              rd_hold    <= bus.rd_in;
              wb_hold    <= (op == MEM_POP32) && bus.wb_en_in;
              sp         <= (op == MEM_POP32) ? sp_inc : sp_dec;
              word_hold  <= (op == MEM_POP32) ? mem_rdata : bus.push32_data[DATA_W-1:0];
            end
            default: begin
              out_valid_q <= 1'b1;
              rd_q        <= bus.rd_in;
              case (op)
                MEM_LOAD: begin
                  result_q <= mem_rdata;
                  wb_en_q  <= bus.wb_en_in;
                end
                MEM_POP: begin
                  sp       <= sp_inc;
                  result_q <= mem_rdata;
                  wb_en_q  <= bus.wb_en_in;
                end
                MEM_STORE, MEM_PUSH: begin
                  if (op == MEM_PUSH) sp <= sp_dec;
                  result_q <= bus.alu_result[DATA_W-1:0];
                  wb_en_q  <= 1'b0;
                end
                default: begin
                  result_q <= bus.alu_result[DATA_W-1:0];
                  wb_en_q  <= bus.wb_en_in;
                end
              endcase
            end
          endcase
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.result32    = result32_q;
  assign bus.rd_out      = rd_q;
  assign bus.wb_en_out   = wb_en_q;
  assign bus.sp_out      = sp;
  assign bus.stack_fault = fault_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with an expected-result queue checked on out_valid.
// Drives on the falling edge and samples on the falling edge after each rising edge.
// Exercises memory ops, 32-bit stack ops, mid-op reset and the stack boundary.
module tb_memory_stage;
  import memory_stage_pkg::*;

  typedef struct {
    logic [15:0] result;
    logic [31:0] result32;
    logic [2:0]  rd;
    logic        wb;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  memory_stage_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  memory_stage #(.ADDR_W(11), .DATA_W(16), .SP_RESET(2047)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [15:0] res, input logic [31:0] r32,
                            input logic [2:0] rd, input logic wb, input logic flt);
    exp_t e;
    e.result = res; e.result32 = r32; e.rd = rd; e.wb = wb; e.fault = flt;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [31:0] p32, input logic [2:0] rd, input logic wb);
    bus.in_valid    = 1'b1;
    bus.mem_op      = op;
    bus.alu_result  = alu;
    bus.store_data  = sd;
    bus.push32_data = p32;
    bus.rd_in       = rd;
    bus.wb_en_in    = wb;
  endtask

  // Compare the DUT output against the oldest queued expectation.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, ".result"},   32'(bus.result),      32'(e.result));
      chk({tag, ".result32"}, bus.result32,         e.result32);
      chk({tag, ".rd"},       32'(bus.rd_out),      32'(e.rd));
      chk({tag, ".wb_en"},    32'(bus.wb_en_out),   32'(e.wb));
      chk({tag, ".fault"},    32'(bus.stack_fault), 32'(e.fault));
    end
  endtask

  // One single-cycle op: drive, queue expectation, let it register, check.
  task automatic single(input string tag, input logic [2:0] op, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [2:0] rd, input logic wb,
                        input logic [15:0] eres, input logic [31:0] er32, input logic ewb,
                        input logic eflt, input logic [10:0] esp);
    drive(op, alu, sd, 32'h0, rd, wb);
    expect_out(eres, er32, rd, ewb, eflt);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out(tag);
    chk({tag, ".sp"}, 32'(bus.sp_out), 32'(esp));
  endtask

  // Two-cycle op with inputs held through SECOND, as upstream does while busy.
  task automatic wide(input string tag, input logic [2:0] op, input logic [31:0] p32,
                      input logic [2:0] rd, input logic wb, input logic [10:0] mid_sp,
                      input logic [15:0] eres, input logic [31:0] er32, input logic ewb,
                      input logic [10:0] esp);
    drive(op, 16'h0, 16'h0, p32, rd, wb);
    #1 chk({tag, ".busy1"}, 32'(bus.busy), 32'd1);
    expect_out(eres, er32, rd, ewb, 1'b0);
    @(negedge clk);
    chk({tag, ".busy2"}, 32'(bus.busy), 32'd0);
    chk({tag, ".vld_mid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".sp_mid"}, 32'(bus.sp_out), 32'(mid_sp));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out(tag);
    chk({tag, ".sp"}, 32'(bus.sp_out), 32'(esp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(3'd0, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.sp",        32'(bus.sp_out),      32'd2047);
    chk("rst.out_valid", 32'(bus.out_valid),   32'd0);
    chk("rst.result",    32'(bus.result),      32'd0);
    chk("rst.busy",      32'(bus.busy),        32'd0);
    chk("rst.wb_en",     32'(bus.wb_en_out),   32'd0);
    chk("rst.fault",     32'(bus.stack_fault), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.out_valid", 32'(bus.out_valid), 32'd0);

    // STORE then LOAD: 1-cycle latency, LOAD writes back.
    single("store", MEM_STORE, 16'h0010, 16'hBEEF, 3'd1, 1'b1, 16'h0010, 32'h0, 1'b0, 1'b0, 11'd2047);
    single("load",  MEM_LOAD,  16'h0010, 16'h0,    3'd2, 1'b1, 16'hBEEF, 32'h0, 1'b1, 1'b0, 11'd2047);
    @(negedge clk);
    chk("hold.out_valid", 32'(bus.out_valid), 32'd0);
    chk("hold.result",    32'(bus.result),    32'h0000BEEF);
    single("nop",  MEM_NOP,  16'h4321, 16'h0, 3'd3, 1'b1, 16'h4321, 32'h0, 1'b1, 1'b0, 11'd2047);
    single("nop7", MEM_NOP7, 16'h0777, 16'h0, 3'd4, 1'b0, 16'h0777, 32'h0, 1'b0, 1'b0, 11'd2047);

    // Stack LIFO order and SP movement.
    single("push1", MEM_PUSH, 16'h00A1, 16'h1234, 3'd0, 1'b1, 16'h00A1, 32'h0, 1'b0, 1'b0, 11'd2046);
    single("push2", MEM_PUSH, 16'h00A2, 16'h5678, 3'd0, 1'b1, 16'h00A2, 32'h0, 1'b0, 1'b0, 11'd2045);
    single("pop1",  MEM_POP,  16'h0,    16'h0,    3'd5, 1'b1, 16'h5678, 32'h0, 1'b1, 1'b0, 11'd2046);
    single("pop2",  MEM_POP,  16'h0,    16'h0,    3'd6, 1'b1, 16'h1234, 32'h0, 1'b1, 1'b0, 11'd2047);

    // 32-bit push/pop round trip; result holds, SP net unchanged.
    wide("push32", MEM_PUSH32, 32'hAAAA5555, 3'd7, 1'b1, 11'd2046, 16'h1234, 32'h0,        1'b0, 11'd2045);
    wide("pop32",  MEM_POP32,  32'h0,        3'd2, 1'b1, 11'd2046, 16'h1234, 32'hAAAA5555, 1'b1, 11'd2047);

    // Reset in the middle of PUSH32: second word never written.
    single("store2046", MEM_STORE, 16'h07FE, 16'hC0DE, 3'd0, 1'b0, 16'h07FE, 32'hAAAA5555, 1'b0, 1'b0, 11'd2047);
    drive(MEM_PUSH32, 16'h0, 16'h0, 32'h11112222, 3'd1, 1'b1);
    #1 chk("rst32.busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("rst32.sp_mid", 32'(bus.sp_out), 32'd2046);
    #1 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1 chk("rst32.sp_async", 32'(bus.sp_out), 32'd2047);
    @(negedge clk);
    rst = 1'b0;
    chk("rst32.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst32.result32",  bus.result32,       32'd0);
    @(negedge clk);
    chk("rst32.sp", 32'(bus.sp_out), 32'd2047);
    single("ld2046", MEM_LOAD, 16'h07FE, 16'h0, 3'd3, 1'b1, 16'hC0DE, 32'h0, 1'b1, 1'b0, 11'd2047);
    single("ld2047", MEM_LOAD, 16'h07FF, 16'h0, 3'd3, 1'b1, 16'h1111, 32'h0, 1'b1, 1'b0, 11'd2047);

    // POP at the top of the stack.
    single("store0", MEM_STORE, 16'h0000, 16'h0A0A, 3'd0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 11'd2047);
`ifdef STACK_GUARD_EN
    single("pop_top", MEM_POP, 16'h0, 16'h0, 3'd4, 1'b1, 16'h0000, 32'h0, 1'b0, 1'b1, 11'd2047);
    single("ld0",     MEM_LOAD, 16'h0000, 16'h0, 3'd5, 1'b1, 16'h0A0A, 32'h0, 1'b1, 1'b0, 11'd2047);
`else
    single("pop_top", MEM_POP,  16'h0,    16'h0,    3'd4, 1'b1, 16'h0A0A, 32'h0, 1'b1, 1'b0, 11'd0);
    single("push_0",  MEM_PUSH, 16'h0055, 16'h0B0B, 3'd0, 1'b1, 16'h0055, 32'h0, 1'b0, 1'b0, 11'd2047);
    single("ld0",     MEM_LOAD, 16'h0000, 16'h0,    3'd5, 1'b1, 16'h0B0B, 32'h0, 1'b1, 1'b0, 11'd2047);
`endif

    chk("queue.drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
